// File: rtl/key_poll_master.sv
// key_poll_master: Avalon-MM master that periodically reads the key PIO data
// register, debounces each key bit, and emits one-cycle press/release pulses.
// Optional feature: define KEY_POLL_IRQ_EN to add the irq/irq_ack pair, where
// irq latches on any press and is cleared by irq_ack.
module key_poll_master #(
  parameter int KEY_W        = 3,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int READ_LATENCY = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [KEY_W-1:0] keys_stable,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
`ifdef KEY_POLL_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_ack
`endif
);

  localparam int TICK_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int LAT_W  = 2;

  typedef enum logic [1:0] {IDLE, REQ, LAT, UPD} state_t;

  state_t             state_reg, state_next;
  logic [LAT_W-1:0]   lat_reg, lat_next;
  logic [TICK_W-1:0]  tick_reg;
  logic               tick_hit;
  logic               poll_pending_reg;
  logic               capture;
  logic [KEY_W-1:0]   sample_reg;
  logic [KEY_W-1:0]   cand_reg;
  logic [CNT_W-1:0]   cnt_reg [KEY_W];
  logic [CNT_W-1:0]   cnt_upd [KEY_W];
  logic [KEY_W-1:0]   accept;

  // Only the low key bits of the data register matter.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:KEY_W];

  assign avm_address = 2'b00;
  assign avm_read    = (state_reg == REQ);
  assign tick_hit    = (tick_reg == TICK_W'(POLL_DIV - 1));

  // Free-running poll divider, wrapping at POLL_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_reg <= '0;
    end else if (tick_hit) begin
      tick_reg <= '0;
    end else begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  // Single pending-poll flag; a new tick wins over the IDLE consume so no tick is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      poll_pending_reg <= 1'b0;
    end else if (tick_hit) begin
      poll_pending_reg <= 1'b1;
    end else if (state_reg == IDLE && poll_pending_reg) begin
      poll_pending_reg <= 1'b0;
    end
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      lat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
    end
  end

  // Next-state logic; capture marks the cycle in which readdata is valid.
  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (poll_pending_reg) state_next = REQ;
      end
      REQ: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            capture    = 1'b1;
            state_next = UPD;
          end else begin
            lat_next   = '0;
            state_next = LAT;
          end
        end
      end
      LAT: begin
        if (lat_reg == LAT_W'(READ_LATENCY - 1)) begin
          capture    = 1'b1;
          state_next = UPD;
        end else begin
          lat_next = lat_reg + 1'b1;
        end
      end
      UPD: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample register holds the polarity-corrected key bits (1 = pressed).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_reg <= '0;
    end else if (capture) begin
      sample_reg <= avm_readdata[KEY_W-1:0] ^ {KEY_W{ACTIVE_LOW != 0}};
    end
  end

  // Per-bit debounce: the candidate always becomes the new sample, so only the
  // counter differs between the match and mismatch cases.
  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_deb
      logic match;
      assign match = (sample_reg[gi] == cand_reg[gi]);
      assign cnt_upd[gi] = !match ? CNT_W'(1) :
                           (cnt_reg[gi] == CNT_W'(DEBOUNCE_CNT)) ? cnt_reg[gi] :
                           cnt_reg[gi] + 1'b1;
      assign accept[gi] = (cnt_upd[gi] == CNT_W'(DEBOUNCE_CNT)) &&
                          (sample_reg[gi] != keys_stable[gi]);
    end
  endgenerate

  // Debounce state and outputs; pulses last the single cycle after UPD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_reg    <= '0;
      keys_stable <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < KEY_W; i++) cnt_reg[i] <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (state_reg == UPD) begin
        cand_reg    <= sample_reg;
        keys_stable <= keys_stable ^ accept;
        key_press   <= accept & sample_reg;
        key_release <= accept & ~sample_reg;
        for (int i = 0; i < KEY_W; i++) cnt_reg[i] <= cnt_upd[i];
      end
    end
  end

`ifdef KEY_POLL_IRQ_EN
  // Interrupt latch: any press sets it, ack clears it, set wins on a tie.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (state_reg == UPD && |(accept & sample_reg)) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/key_poll_master.md
# key_poll_master

Avalon-MM master that periodically reads the 3-bit key PIO data register (offset 0) and turns raw samples into debounced key state and one-cycle press/release pulses for the display controller logic. It sits on the system interconnect as an initiator toward the key PIO slave. It replaces software polling of the keys by the Nios CPU.

## Interface

Parameters:
- `KEY_W`, default 3: number of key bits taken from `avm_readdata[KEY_W-1:0]`.
- `POLL_DIV`, default 50000: clock cycles between poll requests (≥2).
- `DEBOUNCE_CNT`, default 4: consecutive equal polls required to accept a new level (≥1).
- `READ_LATENCY`, default 1: fixed slave read latency in cycles after the accept cycle (0..3).
- `ACTIVE_LOW`, default 1: when 1, a raw 0 bit means the key is pressed.

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset. **One clock; reset is synchronous and active-low.**
- `avm_address`, output, 2: fixed at 0 (PIO data register).
- `avm_read`, output, 1: read request.
- `avm_waitrequest`, input, 1: slave stall.
- `avm_readdata`, input, 32: read data.
- `keys_stable`, output, KEY_W: debounced state, 1 = pressed.
- `key_press`, output, KEY_W: one-cycle pulse per bit on a stable 0→1 change.
- `key_release`, output, KEY_W: one-cycle pulse per bit on a stable 1→0 change.
- `irq`, output, 1: present only with `KEY_POLL_IRQ_EN`.
- `irq_ack`, input, 1: present only with `KEY_POLL_IRQ_EN`.

## Operation

- Tick counter runs 0..POLL_DIV-1 and wraps. At terminal count it sets `poll_pending`. Ticks arriving while `poll_pending` is already set coalesce, so at most one poll is pending.
- FSM states:
  - IDLE: go to REQ when `poll_pending` is set, and clear `poll_pending` in the same cycle.
  - REQ: drive `avm_read`=1 and hold it, with address stable, until a cycle with `avm_waitrequest`=0 (the accept cycle). Then go to LAT, or go directly to UPD with readdata captured in the accept cycle if READ_LATENCY=0.
  - LAT: count READ_LATENCY cycles after the accept. Capture `avm_readdata[KEY_W-1:0]` in the cycle it is valid, i.e. READ_LATENCY cycles after the accept edge. Then go to UPD.
  - UPD: apply the debounce update for one cycle, then go to IDLE.
- Raw sample = captured bits XOR {KEY_W{ACTIVE_LOW}}.
- Per-bit debounce, using `cand[i]` and saturating `cnt[i]` of width clog2(DEBOUNCE_CNT+1):
  - If raw == cand, cnt increments, saturating at DEBOUNCE_CNT.
  - Otherwise cand becomes raw and cnt becomes 1.
  - If the new cnt == DEBOUNCE_CNT and cand != stable, stable becomes cand and the matching press or release bit pulses.
- Upper `avm_readdata` bits are ignored.
- Multiple bits may change in the same UPD. Each bit pulses independently in the same cycle.

## Timing

- Reset values: `avm_read`=0, `keys_stable`=0, `key_press`=0, `key_release`=0, `irq`=0. Internal state also resets: cand=0, cnt=0, tick=0, `poll_pending`=0, FSM in IDLE.
- Reset asserted mid-transaction: `avm_read` is 0 from the first reset edge on. Any in-flight readdata is discarded.
- First `avm_read` assertion: POLL_DIV+1 cycles after the first edge with `reset_n`=1 (tick wrap, then the IDLE→REQ edge).
- With no waitrequest, one poll takes 2+READ_LATENCY cycles from REQ entry back to IDLE.
- Output update: `keys_stable` and the pulses change on the edge that leaves UPD. Pulses are high for exactly one cycle.
- Detection latency: DEBOUNCE_CNT consecutive polls reading the new level. With DEBOUNCE_CNT=1, the first poll showing the change updates the output.
- A waitrequest stall longer than POLL_DIV delays polling only. It never issues overlapping reads.

## Configuration

- Macro `KEY_POLL_IRQ_EN` defined:
  - `irq` is set on the edge where any `key_press` bit pulses.
  - `irq` clears on the edge after `irq_ack`=1.
  - A simultaneous press and ack leaves `irq`=1 (set wins).
- Macro undefined: `irq` and `irq_ack` ports and their logic are absent. All other behaviour is identical.

## Test plan

Bench parameters: POLL_DIV=8, DEBOUNCE_CNT=3, READ_LATENCY=1, ACTIVE_LOW=1.

- Reset, then hold raw keys at 3'b111 → first `avm_read` at cycle 9 after reset release; `keys_stable` stays 0; no pulses.
- Drive raw 3'b110 → after the 3rd poll sees it, `keys_stable`=3'b001 and `key_press`=3'b001 for one cycle. Return raw to 3'b111 → after 3 polls, `key_release`=3'b001 for one cycle.
- Bouncing raw bit 1, alternating 0/1 on each poll for 6 polls, then held at 0 → no pulse until 3 consecutive 0 polls; then exactly one `key_press`=3'b010.
- Slave holds `avm_waitrequest`=1 for 20 cycles → `avm_read` stays high with address 0; only one read is accepted; the next read starts only after UPD.
- Raw 3'b000 presented at once → a single `key_press`=3'b111 pulse. Separately, assert `reset_n`=0 during LAT → `avm_read`=0 and all outputs 0 on the next edge.
- `KEY_POLL_IRQ_EN` defined: after a press, `irq`=1 until `irq_ack`; a press coinciding with ack keeps `irq`=1.
